// File: rtl/button_matrix_pkg.sv
// button_matrix_pkg: shared defaults, event field layout and scanner state encoding
package button_matrix_pkg;
    localparam int ROWS_DEF = 12;
    localparam int COLS_DEF = 18;
    localparam int RW = $clog2(ROWS_DEF);
    localparam int CW = $clog2(COLS_DEF);
    localparam int COL_LSB = 0;
    localparam int ROW_LSB = CW;
    localparam int PRESSED_BIT = RW + CW;
    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, UPDATE, HOLD} state_t;
endpackage

// File: rtl/button_matrix_scanner_fifo.sv
// button_event_fifo: show-ahead event queue; a push into a full queue succeeds only alongside a pop
module button_event_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 10
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign data = mem[rd_ptr];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/button_matrix_scanner.sv
// button_matrix_scanner: row-by-row matrix scan with per-key debounce, event FIFO and bitmap read port
module button_matrix_scanner import button_matrix_pkg::*; #(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int ROW_CYCLES = 4000,
    parameter int SETTLE_CYCLES = 48,
    parameter int DB_SCANS = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                scan_en,
    output logic [ROWS-1:0]                     row_n,
    input  logic [COLS-1:0]                     col_n,
    output logic                                ev_valid,
    input  logic                                ev_ready,
    output logic [$clog2(ROWS)+$clog2(COLS):0]  ev_data,
    output logic [$clog2(FIFO_DEPTH):0]         ev_count,
    output logic                                overflow,
    input  logic                                ovf_clr,
    input  logic [$clog2(ROWS)-1:0]             rd_row,
    output logic [COLS-1:0]                     rd_cols
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int EW = ROW_W + COL_W + 1;
    localparam int TW = $clog2(ROW_CYCLES);
    state_t state, state_nx;
    logic [TW-1:0] tick;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    logic [COLS-1:0] col_s1, col_s2, samp;
    logic [COLS-1:0] st [ROWS];
    logic [2:0] cnt [ROWS][COLS];
    logic last_tick, raw_bit, cur_st, flip, push_q, full, empty, pop;
    logic [2:0] cur_cnt;
    logic [EW-1:0] push_data_q;
    assign last_tick = tick == TW'(ROW_CYCLES - 1);
    assign raw_bit = samp[c];
    assign cur_st = st[r][c];
    assign cur_cnt = cnt[r][c];
    assign flip = state == UPDATE && raw_bit != cur_st && cur_cnt == 3'(DB_SCANS - 1);
    assign ev_valid = ~empty;
    assign pop = ev_valid & ev_ready;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = scan_en ? DRIVE : IDLE;
            DRIVE:   state_nx = tick == TW'(SETTLE_CYCLES - 1) ? SAMPLE : DRIVE;
            SAMPLE:  state_nx = UPDATE;
            UPDATE:  state_nx = c == COL_W'(COLS - 1) ? HOLD : UPDATE;
            HOLD:    state_nx = !last_tick ? HOLD : scan_en ? DRIVE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Row drive is decoded from registered state so an async reset releases the row at once
    always_comb begin
        row_n = state == IDLE ? '1 : ~(ROWS'(1) << r);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick <= '0;
            r <= '0;
            c <= '0;
            col_s1 <= '1;
            col_s2 <= '1;
            samp <= '0;
        end else begin
            col_s1 <= col_n;
            col_s2 <= col_s1;
            tick <= (state == IDLE || last_tick) ? '0 : tick + TW'(1);
            samp <= state == SAMPLE ? ~col_s2 : samp;
            c <= (state == UPDATE && c != COL_W'(COLS - 1)) ? c + COL_W'(1) : '0;
            if (state == HOLD && last_tick) r <= r == ROW_W'(ROWS - 1) ? '0 : r + ROW_W'(1);
        end
    end
    // A dropped event still commits the key state so the bitmap never lags the debouncer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ROWS; i++) begin
                st[i] <= '0;
                for (int j = 0; j < COLS; j++) cnt[i][j] <= '0;
            end
            push_q <= 1'b0;
            push_data_q <= '0;
            rd_cols <= '0;
            overflow <= 1'b0;
        end else begin
            push_q <= flip;
            push_data_q <= {raw_bit, r, c};
            if (state == UPDATE) begin
                cnt[r][c] <= (raw_bit == cur_st || flip) ? 3'd0 : cur_cnt + 3'd1;
                if (flip) st[r][c] <= raw_bit;
            end
            rd_cols <= int'(rd_row) < ROWS ? st[rd_row] : '0;
            overflow <= (push_q && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end
    button_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk(clk),
        .resetn(resetn),
        .push(push_q),
        .push_data(push_data_q),
        .pop(pop),
        .data(ev_data),
        .full(full),
        .empty(empty),
        .count(ev_count)
    );
endmodule

// File: tb/tb_button_matrix_scanner.sv
// tb_button_matrix_scanner: directed checks of scan order, debounce, FIFO overflow, reset and stop
module tb_button_matrix_scanner;
    import button_matrix_pkg::*;
    logic clk = 1'b0, resetn = 1'b0, scan_en = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
    logic [11:0] row_n;
    logic [17:0] col_n, rd_cols;
    logic ev_valid, overflow;
    logic [9:0] ev_data;
    logic [4:0] ev_count;
    logic [3:0] rd_row = 4'd0;
    logic [17:0] pressed [12];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_n = '1;
        for (int rr = 0; rr < 12; rr++) if (!row_n[rr]) col_n = col_n & ~pressed[rr];
    end

    button_matrix_scanner #(.ROW_CYCLES(80), .SETTLE_CYCLES(8), .DB_SCANS(3)) dut (
        .clk(clk), .resetn(resetn), .scan_en(scan_en), .row_n(row_n), .col_n(col_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_count(ev_count),
        .overflow(overflow), .ovf_clr(ovf_clr), .rd_row(rd_row), .rd_cols(rd_cols)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_row0();
        logic [11:0] p;
        int n;
        n = 0;
        p = row_n;
        @(negedge clk);
        while (!(row_n == 12'hFFE && p != 12'hFFE) && n < 3000) begin
            p = row_n;
            @(negedge clk);
            n++;
        end
        chk("frame_start_timeout", 32'(n < 3000), 32'd1);
    endtask

    task automatic pop1();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    function automatic logic [9:0] ev(input logic p, input int r, input int c);
        logic [9:0] e;
        e = '0;
        e[PRESSED_BIT] = p;
        e[ROW_LSB +: 4] = 4'(r);
        e[COL_LSB +: 5] = 5'(c);
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_row;
        int held, n;
        for (int rr = 0; rr < 12; rr++) pressed[rr] = '0;
        step(3);
        chk("rst_row_n", row_n, 12'hFFF);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_count", ev_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_cols", rd_cols, 0);
        resetn = 1'b1;
        step(2);
        scan_en = 1'b1;
        n = 0;
        while (row_n == 12'hFFF && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 13; k++) begin
            exp_row = ~(12'd1 << (k % 12));
            held = 1;
            chk("row_drive", row_n, exp_row);
            for (int i = 1; i < 80; i++) begin
                @(negedge clk);
                if (row_n !== exp_row) held = 0;
            end
            chk("row_hold_80", held, 1);
            @(negedge clk);
        end
        chk("idle_scan_no_events", ev_valid, 0);

        wait_row0();
        pressed[2][5] = 1'b1;
        wait_row0();
        wait_row0();
        chk("press_not_early", ev_count, 0);
        wait_row0();
        pressed[2][5] = 1'b0;
        chk("press_valid", ev_valid, 1);
        chk("press_count", ev_count, 1);
        chk("press_data", ev_data, 10'b1_0010_00101);
        rd_row = 4'd2;
        step(1);
        chk("bitmap_row2", rd_cols, 18'h00020);
        pop1();
        chk("press_popped", ev_count, 0);
        wait_row0();
        wait_row0();
        chk("release_not_early", ev_count, 0);
        wait_row0();
        chk("release_count", ev_count, 1);
        chk("release_data", ev_data, 10'b0_0010_00101);
        chk("bitmap_row2_clear", rd_cols, 0);
        pop1();

        wait_row0();
        pressed[7][17] = 1'b1;
        wait_row0();
        wait_row0();
        pressed[7][17] = 1'b0;
        wait_row0();
        pressed[7][17] = 1'b1;
        wait_row0();
        wait_row0();
        chk("bounce_no_event_yet", ev_count, 0);
        wait_row0();
        chk("bounce_one_event", ev_count, 1);
        chk("bounce_data", ev_data, ev(1'b1, 7, 17));
        pop1();

        wait_row0();
        for (int c = 0; c < 17; c++) pressed[0][c] = 1'b1;
        wait_row0();
        wait_row0();
        wait_row0();
        chk("full_count", ev_count, 16);
        chk("full_overflow", overflow, 1);
        chk("full_head", ev_data, ev(1'b1, 0, 0));
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        wait_row0();
        pressed[7][17] = 1'b0;
        wait_row0();
        wait_row0();
        // Release of (7,17) is pushed at frame offset 7*80 + 8 + 1 + 17 + 1 = 587
        step(587);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        chk("pop_push_count", ev_count, 16);
        chk("pop_push_no_ovf", overflow, 0);
        for (int c = 1; c < 16; c++) begin
            chk("drain_press", ev_data, ev(1'b1, 0, c));
            pop1();
        end
        chk("drain_tail_release", ev_data, ev(1'b0, 7, 17));
        pop1();
        chk("drained", ev_count, 0);

        wait_row0();
        for (int c = 0; c < 4; c++) pressed[0][c] = 1'b0;
        wait_row0();
        wait_row0();
        wait_row0();
        chk("four_queued", ev_count, 4);
        step(12);
        resetn = 1'b0;
        for (int rr = 0; rr < 12; rr++) pressed[rr] = '0;
        #1;
        chk("async_rst_row_n", row_n, 12'hFFF);
        chk("async_rst_ev_valid", ev_valid, 0);
        chk("async_rst_ev_count", ev_count, 0);
        step(2);
        resetn = 1'b1;
        rd_row = 4'd0;
        step(2);
        chk("rst_bitmap_cleared", rd_cols, 0);

        wait_row0();
        step(322);
        chk("stop_row4_driven", row_n, 12'hFEF);
        scan_en = 1'b0;
        step(77);
        chk("stop_row4_finishes", row_n, 12'hFEF);
        step(1);
        chk("stop_idle", row_n, 12'hFFF);
        step(200);
        chk("stop_stays_idle", row_n, 12'hFFF);
        chk("stop_no_events", ev_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
